// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, instruction field
// positions, jump condition codes and the halt opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXEC    = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam int IR_IMM     = 7;
  localparam int IR_JMP     = 6;
  localparam int IR_COND_HI = 5;
  localparam int IR_COND_LO = 4;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_NZ     = 2'b11;

  localparam logic [7:0] HALT_OPCODE = 8'h7F;

  // A jump only exists when the target byte follows the opcode.
  function automatic logic is_jump(input logic [7:0] instr);
    return instr[IR_IMM] & instr[IR_JMP];
  endfunction

endpackage

// File: rtl/jump_cond.sv
// Combinational evaluation of an instruction's COND field against the ALU flags.
module jump_cond
  import fetch_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flag_z;
      COND_C:      taken = flag_c;
      COND_NZ:     taken = ~flag_z;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/operand/execute sequencer driving an external program counter.
// Optional halt opcode support is enabled with the FETCH_HALT_EN macro.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       pc_inc,
  output logic       do_jump,
  output logic [7:0] dbus,
  output logic [7:0] ir,
  output logic       exec,
  output logic       halted
);

  state_t     state;
  logic [7:0] operand;
  logic       cond_ok;

  jump_cond u_jump_cond (
    .cond   (ir[IR_COND_HI:IR_COND_LO]),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .taken  (cond_ok)
  );

  assign rom_addr = pc;
  assign dbus     = operand;
  // Flags are sampled live in EXEC, so the jump request cannot be registered.
  assign do_jump  = (state == ST_EXEC) & is_jump(ir) & cond_ok;

`ifdef FETCH_HALT_EN
  logic halt_q;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      ir      <= 8'h00;
      operand <= 8'h00;
      pc_inc  <= 1'b1;
      exec    <= 1'b0;
`ifdef FETCH_HALT_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          ir <= rom_data;
`ifdef FETCH_HALT_EN
          if (rom_data == HALT_OPCODE) begin
            state  <= ST_HALT;
            pc_inc <= 1'b0;
            exec   <= 1'b0;
            halt_q <= 1'b1;
          end else
`endif
          if (rom_data[IR_IMM]) begin
            state  <= ST_OPERAND;
            pc_inc <= 1'b1;
            exec   <= 1'b0;
          end else begin
            state  <= ST_EXEC;
            pc_inc <= 1'b0;
            exec   <= 1'b1;
          end
        end
        ST_OPERAND: begin
          operand <= rom_data;
          state   <= ST_EXEC;
          pc_inc  <= 1'b0;
          exec    <= 1'b1;
        end
        ST_EXEC: begin
          state  <= ST_FETCH;
          pc_inc <= 1'b1;
          exec   <= 1'b0;
        end
        ST_HALT: begin
          // Only reset leaves HALT.
          state  <= ST_HALT;
          pc_inc <= 1'b0;
          exec   <= 1'b0;
        end
        default: begin
          state  <= ST_FETCH;
          pc_inc <= 1'b1;
          exec   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a bench-side ROM and program counter.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic       pc_inc, do_jump, exec, halted;
  logic [7:0] dbus, ir;

  logic [7:0] rom [256];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         r;

  typedef struct {
    logic [7:0] ir;
    logic       jmp;
    logic [7:0] dbus;
    logic [7:0] npc;
    int         ecyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic pend = 1'b0;

  fetch_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .pc_inc   (pc_inc),
    .do_jump  (do_jump),
    .dbus     (dbus),
    .ir       (ir),
    .exec     (exec),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) pc <= 8'h00;
    else if (do_jump) pc <= dbus;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation per exec strobe, then checks the following fetch.
  always @(negedge clk) begin
    check("jump_exclusive", {31'd0, do_jump & (pc_inc | ~exec)}, 32'd0);
    if (pend) begin
      pend = 1'b0;
      check("next_pc", {24'd0, pc}, {24'd0, cur.npc});
      check("next_fetch", {30'd0, pc_inc, exec}, 32'd2);
    end
    if (exec && q.size() > 0) begin
      cur = q.pop_front();
      check("exec_cycle", cyc, cur.ecyc);
      check("ir", {24'd0, ir}, {24'd0, cur.ir});
      check("do_jump", {31'd0, do_jump}, {31'd0, cur.jmp});
      check("dbus", {24'd0, dbus}, {24'd0, cur.dbus});
      pend = 1'b1;
    end
  end

  task automatic push(input logic [7:0] i, input logic j, input logic [7:0] d,
                      input logic [7:0] n, input int c);
    exp_t e;
    e.ir = i; e.jmp = j; e.dbus = d; e.npc = n; e.ecyc = c;
    q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Holds reset two cycles, checks reset outputs, releases at a negedge; r = release cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {pc_inc, do_jump, exec, halted, dbus, ir},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    check("rst_pc", {24'd0, pc}, 32'd0);
    reset = 1'b0;
    r = cyc;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q.size() > 0 || pend) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_drained"}, {31'd0, (q.size() > 0 || pend)}, 32'd0);
    q.delete();
    pend = 1'b0;
  endtask

  initial begin
    clear_rom();

    // Simple non-immediate instruction; first fetch right after reset.
    rom[0] = 8'h01;
    do_reset();
    check("first_fetch", {pc_inc, exec, pc}, {1'b1, 1'b0, 8'h00});
    push(8'h01, 1'b0, 8'h00, 8'h01, r + 1);
    push(8'h00, 1'b0, 8'h00, 8'h02, r + 3);
    drain("nonimm");

    // Unconditional jump, then operand retained through a plain instruction.
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h20; rom[8'h20] = 8'h01;
    do_reset();
    push(8'hC0, 1'b1, 8'h20, 8'h20, r + 2);
    push(8'h01, 1'b0, 8'h20, 8'h21, r + 4);
    drain("jmp_always");

    // Jump on Z, flag clear then set.
    clear_rom();
    rom[0] = 8'hD0; rom[1] = 8'h20;
    flag_z = 1'b0;
    do_reset();
    push(8'hD0, 1'b0, 8'h20, 8'h02, r + 2);
    drain("jz_not_taken");
    flag_z = 1'b1;
    do_reset();
    push(8'hD0, 1'b1, 8'h20, 8'h20, r + 2);
    drain("jz_taken");

    // Jump on C taken, jump on not-Z suppressed, JMP without IMM is a no-op.
    clear_rom();
    rom[0] = 8'hE0; rom[1] = 8'h10;
    rom[8'h10] = 8'hF0; rom[8'h11] = 8'h44;
    rom[8'h12] = 8'h70;
    flag_z = 1'b1; flag_c = 1'b1;
    do_reset();
    push(8'hE0, 1'b1, 8'h10, 8'h10, r + 2);
    push(8'hF0, 1'b0, 8'h44, 8'h12, r + 5);
    push(8'h70, 1'b0, 8'h44, 8'h13, r + 7);
    drain("cond_mix");
    flag_z = 1'b0; flag_c = 1'b0;

    // Immediate at the top of memory wraps the PC back to zero.
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'hFE; rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h55;
    do_reset();
    push(8'hC0, 1'b1, 8'hFE, 8'hFE, r + 2);
    push(8'h80, 1'b0, 8'h55, 8'h00, r + 5);
    drain("wrap");

    // Reset asserted while in OPERAND aborts the instruction.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h33;
    do_reset();
    @(negedge clk);
    check("in_operand", {pc_inc, exec, pc}, {1'b1, 1'b0, 8'h01});
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {pc_inc, do_jump, exec, ir, dbus},
          {1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    check("abort_pc", {24'd0, pc}, 32'd0);

    // Halt opcode.
    clear_rom();
    rom[0] = 8'h7F; rom[1] = 8'h01;
    do_reset();
`ifdef FETCH_HALT_EN
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check("halt_hold", {halted, pc_inc, do_jump, exec, pc}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h01});
      @(negedge clk);
    end
    do_reset();
    check("halt_cleared", {31'd0, halted}, 32'd0);
`else
    push(8'h7F, 1'b0, 8'h00, 8'h01, r + 1);
    push(8'h01, 1'b0, 8'h00, 8'h02, r + 3);
    drain("halt_noop");
    check("halted_tied", {31'd0, halted}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
